uart_rx_os: RTL and testbench

//   Oversampling UART receiver, downstream of the baud/oversample timer.

---
 rtl/uart_rx_os_pkg.sv | 17 +
 rtl/uart_rx_os_if.sv | 26 ++
 rtl/uart_rx_os_sync_2ff.sv | 29 ++
 rtl/uart_rx_os.sv | 138 +++++++++++++
 tb/tb_uart_rx_os.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_os_pkg.sv
// Shared UART constants: frame defaults, line levels and receiver state codes.
// Imported by the receiver, its synchronizer and the port interface.
package uart_rx_os_pkg;

  localparam int DEF_DBITS = 8;
  localparam int DEF_OS    = 16;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic STOP_LVL  = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver port bundle: timer tick and raw line in, byte and strobes out.
// master is the line/timer side, slave is the receiver.
interface uart_rx_os_if
  import uart_rx_os_pkg::*;
#(
  parameter int DBITS = DEF_DBITS
);

  logic             tick;
  logic             rx;
  logic [DBITS-1:0] data;
  logic             valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output tick, rx,
    input  data, valid, frame_err, busy
  );

  modport slave (
    input  tick, rx,
    output data, valid, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_os_sync_2ff.sv
// 1-bit two-flop synchronizer for an asynchronous input.
// RST_VAL sets both flops on reset so the output starts at a known level.
module uart_rx_os_sync_2ff
  import uart_rx_os_pkg::*;
#(
  parameter logic RST_VAL = LINE_IDLE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver driven by an external OS-per-bit tick.
// Samples mid-bit, strobes valid on a good stop bit, frame_err otherwise.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int DBITS = DEF_DBITS,
  parameter int OS    = DEF_OS
) (
  input  logic        clk,
  input  logic        rst,
  uart_rx_os_if.slave bus
);

  localparam int SW = $clog2(OS);
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  logic rx_s;

  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    s_cnt_q, s_cnt_d;
  logic [NW-1:0]    n_q, n_d;
  logic [DBITS-1:0] shreg_q, shreg_d;
  logic [DBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  uart_rx_os_sync_2ff #(
    .RST_VAL(LINE_IDLE)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.rx),
    .q  (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The detecting cycle's tick is deliberately not counted.
        if (rx_s != LINE_IDLE) begin
          state_d = ST_START;
          s_cnt_d = '0;
        end
      end
      ST_START: begin
        if (bus.tick) begin
          if (s_cnt_q == S_HALF) begin
            if (rx_s != LINE_IDLE) begin
              state_d = ST_DATA;
              s_cnt_d = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
      end
      ST_DATA: begin
        if (bus.tick) begin
          if (s_cnt_q == S_LAST) begin
            shreg_d = {rx_s, shreg_q[DBITS-1:1]};
            s_cnt_d = '0;
            if (n_q == N_LAST) state_d = ST_STOP;
            else n_d = n_q + N_ONE;
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
      end
      ST_STOP: begin
        if (bus.tick) begin
          if (s_cnt_q == S_LAST) begin
            if (rx_s == STOP_LVL) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so it is not re-read as frames.
        if (rx_s == LINE_IDLE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_cnt_q <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus random frames
// compared against a frame-level timing/data model.
module tb_uart_rx_os;

  localparam int DBITS = 8;
  localparam int OS    = 16;
  localparam int TICKS = OS / 2 + DBITS * OS + OS;
  localparam int LAT   = 3 + TICKS;
  localparam int MAXC  = 16384;

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } vrec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_os_if #(.DBITS(DBITS)) bus ();

  uart_rx_os #(
    .DBITS(DBITS),
    .OS   (OS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    both_cnt = 0;
  int    tick_div = 1;
  logic  tick_log [MAXC];
  logic  busy_log [MAXC];
  vrec_t vq[$];
  int    eq[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < MAXC) tick_log[cyc] = bus.tick;
  end

  always @(negedge clk) begin
    if (cyc < MAXC) busy_log[cyc] = bus.busy;
    if (bus.valid === 1'b1) vq.push_back('{cyc, bus.data});
    if (bus.frame_err === 1'b1) eq.push_back(cyc);
    if (bus.valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.tick = (tick_div <= 1) ? 1'b1 : ((cyc % tick_div) == 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int bitc, output int k);
    k = cyc;
    bus.rx = 1'b0;
    repeat (bitc) step();
    for (int i = 0; i < DBITS; i++) begin
      bus.rx = d[i];
      repeat (bitc) step();
    end
    bus.rx = stop;
    repeat (bitc) step();
  endtask

  task automatic clear_q();
    vq.delete();
    eq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx = 1'b1;
    bus.tick = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.data !== 8'h00) begin
      failures++; $display("FAIL reset_data: got %0h want 0", bus.data);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b want 0", bus.valid);
    end
    checks++;
    if (bus.frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    rst = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_frame_a5();
    int k;
    clear_q();
    send_frame(8'hA5, 1'b1, OS, k);
    repeat (10) step();
    checks++;
    if (vq.size() != 1) begin
      failures++; $display("FAIL a5_count: got %0d want 1", vq.size());
    end else begin
      checks++;
      if (vq[0].d !== 8'hA5) begin
        failures++; $display("FAIL a5_data: got %0h want a5", vq[0].d);
      end
      checks++;
      if (vq[0].cyc != k + LAT) begin
        failures++; $display("FAIL a5_lat: got %0d want %0d", vq[0].cyc, k + LAT);
      end
    end
    checks++;
    if (eq.size() != 0) begin
      failures++; $display("FAIL a5_ferr: got %0d want 0", eq.size());
    end
    checks++;
    if (busy_log[k + 80] !== 1'b1) begin
      failures++; $display("FAIL a5_busy_mid: got %b want 1", busy_log[k + 80]);
    end
    checks++;
    if (busy_log[k + LAT - 1] !== 1'b1 || busy_log[k + LAT] !== 1'b0) begin
      failures++;
      $display("FAIL a5_busy_fall: got %b%b want 10",
               busy_log[k + LAT - 1], busy_log[k + LAT]);
    end
  endtask

  task automatic test_glitch();
    int k;
    clear_q();
    k = cyc;
    bus.rx = 1'b0;
    repeat (4) step();
    bus.rx = 1'b1;
    repeat (30) step();
    checks++;
    if (vq.size() != 0 || eq.size() != 0) begin
      failures++;
      $display("FAIL glitch_strobe: got v=%0d e=%0d want 0 0", vq.size(), eq.size());
    end
    checks++;
    if (busy_log[k + 3 + OS / 2 - 1] !== 1'b1 || busy_log[k + 3 + OS / 2] !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy: got %b%b want 10",
               busy_log[k + 3 + OS / 2 - 1], busy_log[k + 3 + OS / 2]);
    end
    checks++;
    if (bus.data !== 8'hA5) begin
      failures++; $display("FAIL glitch_data: got %0h want a5", bus.data);
    end
  endtask

  task automatic test_break();
    int k;
    int r;
    clear_q();
    send_frame(8'h3C, 1'b0, OS, k);
    repeat (40 * OS) step();
    r = cyc;
    bus.rx = 1'b1;
    repeat (10) step();
    checks++;
    if (eq.size() != 1) begin
      failures++; $display("FAIL brk_count: got %0d want 1", eq.size());
    end else begin
      checks++;
      if (eq[0] != k + LAT) begin
        failures++; $display("FAIL brk_lat: got %0d want %0d", eq[0], k + LAT);
      end
    end
    checks++;
    if (vq.size() != 0) begin
      failures++; $display("FAIL brk_valid: got %0d want 0", vq.size());
    end
    checks++;
    if (bus.data !== 8'hA5) begin
      failures++; $display("FAIL brk_data: got %0h want a5", bus.data);
    end
    checks++;
    if (busy_log[k + LAT] !== 1'b1 || busy_log[r + 2] !== 1'b1 ||
        busy_log[r + 3] !== 1'b0) begin
      failures++;
      $display("FAIL brk_busy: got %b%b%b want 110",
               busy_log[k + LAT], busy_log[r + 2], busy_log[r + 3]);
    end
  endtask

  task automatic test_back_to_back();
    int k1;
    int k2;
    clear_q();
    send_frame(8'h00, 1'b1, OS, k1);
    send_frame(8'hFF, 1'b1, OS, k2);
    repeat (10) step();
    checks++;
    if (vq.size() != 2) begin
      failures++; $display("FAIL b2b_count: got %0d want 2", vq.size());
    end else begin
      checks++;
      if (vq[0].d !== 8'h00 || vq[0].cyc != k1 + LAT) begin
        failures++;
        $display("FAIL b2b_first: got %0h@%0d want 0@%0d", vq[0].d, vq[0].cyc, k1 + LAT);
      end
      checks++;
      if (vq[1].d !== 8'hFF || vq[1].cyc != k2 + LAT) begin
        failures++;
        $display("FAIL b2b_second: got %0h@%0d want ff@%0d", vq[1].d, vq[1].cyc, k2 + LAT);
      end
    end
    checks++;
    if (eq.size() != 0) begin
      failures++; $display("FAIL b2b_ferr: got %0d want 0", eq.size());
    end
  endtask

  task automatic test_reset_mid();
    int         k;
    logic [7:0] d;
    d = 8'h55;
    clear_q();
    bus.rx = 1'b0;
    repeat (OS) step();
    for (int i = 0; i < 3; i++) begin
      bus.rx = d[i];
      repeat (OS) step();
    end
    step();
    bus.rx = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.data !== 8'h00 || bus.valid !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outs: got d=%0h v=%b e=%b b=%b want 0 0 0 0",
               bus.data, bus.valid, bus.frame_err, bus.busy);
    end
    repeat (20) step();
    checks++;
    if (vq.size() != 0 || eq.size() != 0) begin
      failures++;
      $display("FAIL rstmid_strobe: got v=%0d e=%0d want 0 0", vq.size(), eq.size());
    end
    clear_q();
    send_frame(d, 1'b1, OS, k);
    repeat (10) step();
    checks++;
    if (vq.size() != 1) begin
      failures++; $display("FAIL rstmid_count: got %0d want 1", vq.size());
    end else begin
      checks++;
      if (vq[0].d !== 8'h55 || vq[0].cyc != k + LAT) begin
        failures++;
        $display("FAIL rstmid_frame: got %0h@%0d want 55@%0d", vq[0].d, vq[0].cyc, k + LAT);
      end
    end
  endtask

  task automatic test_slow_tick();
    int k;
    int e;
    int cnt;
    tick_div = 4;
    repeat (8) step();
    clear_q();
    send_frame(8'h81, 1'b1, 4 * OS, k);
    repeat (40) step();
    e = -1;
    cnt = 0;
    for (int j = k + 4; j < cyc && e < 0; j++) begin
      if (tick_log[j] === 1'b1) cnt++;
      if (cnt == TICKS) e = j;
    end
    checks++;
    if (vq.size() != 1) begin
      failures++; $display("FAIL slow_count: got %0d want 1", vq.size());
    end else begin
      checks++;
      if (vq[0].d !== 8'h81 || vq[0].cyc != e) begin
        failures++;
        $display("FAIL slow_frame: got %0h@%0d want 81@%0d", vq[0].d, vq[0].cyc, e);
      end
    end
    tick_div = 1;
    repeat (4) step();
  endtask

  task automatic test_random();
    vrec_t      exp_v[$];
    int         exp_e[$];
    logic [7:0] last;
    logic [7:0] d;
    logic       stop;
    int         k;
    last = 8'h81;
    clear_q();
    for (int f = 0; f < 6; f++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, OS, k);
      if (stop) begin
        exp_v.push_back('{k + LAT, d});
        last = d;
      end else begin
        exp_e.push_back(k + LAT);
        repeat ($urandom_range(0, 40)) step();
        bus.rx = 1'b1;
        repeat (5) step();
      end
      repeat ($urandom_range(0, 12)) step();
    end
    repeat (10) step();
    checks++;
    if (vq.size() != exp_v.size() || eq.size() != exp_e.size()) begin
      failures++;
      $display("FAIL rnd_count: got v=%0d e=%0d want %0d %0d",
               vq.size(), eq.size(), exp_v.size(), exp_e.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (vq[i].d !== exp_v[i].d || vq[i].cyc != exp_v[i].cyc) begin
          failures++;
          $display("FAIL rnd_frame%0d: got %0h@%0d want %0h@%0d",
                   i, vq[i].d, vq[i].cyc, exp_v[i].d, exp_v[i].cyc);
        end
      end
      foreach (exp_e[i]) begin
        checks++;
        if (eq[i] != exp_e[i]) begin
          failures++; $display("FAIL rnd_ferr%0d: got %0d want %0d", i, eq[i], exp_e[i]);
        end
      end
    end
    checks++;
    if (bus.data !== last) begin
      failures++; $display("FAIL rnd_data: got %0h want %0h", bus.data, last);
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.tick = 1'b1;
    test_reset();
    test_frame_a5();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_slow_tick();
    test_random();
    checks++;
    if (both_cnt != 0) begin
      failures++; $display("FAIL both_strobes: got %0d want 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
